// File: rtl/l1_mau_pkg.sv
// Shared types and default geometry for the L1 memory-access sequencer.
// Default geometry: 32-bit address and data, 256-bit line, so 8 beats per refill.
package l1_mau_pkg;
    localparam int L1_ADDR_W = 32;
    localparam int L1_DATA_W = 32;
    localparam int L1_LINE_W = 256;
    localparam int WORDS     = L1_LINE_W / L1_DATA_W;
    localparam int OFFS_W    = $clog2(L1_LINE_W / 8);

    typedef enum logic [1:0] {IDLE, I_FILL, D_ACC, RESP} state_t;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_t;
endpackage

// File: rtl/l1_mau_arb_if.sv
// Wishbone B4 pipelined bus between the L1 sequencer (master) and memory (slave).
interface l1_mau_arb_if
    import l1_mau_pkg::*;
#(
    parameter int ADDR_W = L1_ADDR_W,
    parameter int DATA_W = L1_DATA_W,
    parameter int BE_W   = DATA_W / 8
);
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_stall_i;
    logic              wb_err_i;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [BE_W-1:0]   wb_sel_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;

    modport master (
        input  wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o
    );
    modport slave (
        output wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o
    );
endinterface

// File: rtl/l1_rr_arb2.sv
// Two-input round-robin arbiter; req[0]=L1I, req[1]=L1D. On a tie the side that
// did not win last time gets the grant; last_grant moves only on advance.
module l1_rr_arb2
    import l1_mau_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output grant_t     last_grant
);
    always_comb begin
        // NOTE: gnt gets a default before the case so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_I) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_D;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1] ? GNT_D : GNT_I;
        end
    end
endmodule

// File: rtl/l1_mau_arb.sv
// Memory-access sequencer: arbitrates L1I line refills and L1D word accesses onto
// one Wishbone B4 pipelined master; refills are WORDS-beat bursts, L1D is one beat.
module l1_mau_arb
    import l1_mau_pkg::*;
#(
    parameter int ADDR_W = L1_ADDR_W,
    parameter int DATA_W = L1_DATA_W,
    parameter int LINE_W = L1_LINE_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1i_req_val,
    input  logic [ADDR_W-1:0] l1i_req_addr,
    output logic              l1i_req_ack,
    output logic [LINE_W-1:0] l1i_ack_data,
    input  logic              l1d_req_val,
    input  logic              l1d_req_we,
    input  logic [ADDR_W-1:0] l1d_req_addr,
    input  logic [DATA_W-1:0] l1d_req_wdata,
    input  logic [BE_W-1:0]   l1d_req_be,
    output logic              l1d_req_ack,
    output logic [DATA_W-1:0] l1d_ack_data,
    l1_mau_arb_if.master      wb
);
    localparam int NWORDS = LINE_W / DATA_W;
    localparam int BOFF_W = $clog2(BE_W);
    localparam int CNT_W  = $clog2(NWORDS) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((LINE_W / 8) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

    state_t            state, state_nxt;
    grant_t            cur, unused_last_grant;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q, d_data_q;
    logic [BE_W-1:0]   be_q;
    logic [CNT_W-1:0]  issue_cnt, ack_cnt, issue_tot;
    logic [LINE_W-1:0] line_q, line_nxt, i_data_q;
    logic              busy, stb, accept, ack_ok, last_ack;
    logic              unused_err;

    l1_rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({l1d_req_val, l1i_req_val}),
        .advance    (state == IDLE),
        .gnt        (gnt),
        .last_grant (unused_last_grant)
    );

    assign busy      = (state == I_FILL) || (state == D_ACC);
    assign stb       = ((state == I_FILL) && (issue_cnt < CNT_W'(NWORDS))) ||
                       ((state == D_ACC) && (issue_cnt == '0));
    assign accept    = stb && !wb.wb_stall_i;
    // An ack may arrive with the strobe it answers, so this cycle's acceptance counts as issued.
    assign issue_tot = issue_cnt + CNT_W'(accept);
    assign ack_ok    = busy && wb.wb_ack_i && (ack_cnt < issue_tot);
    assign last_ack  = ack_ok && ((state == D_ACC) || (ack_cnt == CNT_W'(NWORDS - 1)));
    assign unused_err = wb.wb_err_i;

    assign wb.wb_cyc_o = busy;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = (state == D_ACC) && we_q;
    assign wb.wb_adr_o = stb ? (addr_q + (ADDR_W'(issue_cnt) << BOFF_W)) : '0;
    assign wb.wb_dat_o = (stb && (state == D_ACC)) ? wdata_q : '0;
    assign wb.wb_sel_o = !stb ? '0 : ((state == D_ACC) ? be_q : '1);

    assign l1i_req_ack  = (state == RESP) && (cur == GNT_I);
    assign l1d_req_ack  = (state == RESP) && (cur == GNT_D);
    assign l1i_ack_data = i_data_q;
    assign l1d_ack_data = d_data_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (gnt[0]) state_nxt = I_FILL;
                           else if (gnt[1]) state_nxt = D_ACC;
            I_FILL, D_ACC: if (last_ack) state_nxt = RESP;
            RESP:          state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        line_nxt = line_q;
        if ((state == I_FILL) && ack_ok)
            line_nxt[int'(ack_cnt[CNT_W-2:0])*DATA_W +: DATA_W] = wb.wb_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the line and ack-data registers are reset too, so ack_data reads 0 out of reset.
        if (!rst_n) begin
            cur       <= GNT_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            issue_cnt <= '0;
            ack_cnt   <= '0;
            line_q    <= '0;
            i_data_q  <= '0;
            d_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    ack_cnt   <= '0;
                    if (gnt != 2'b00) begin
                        cur     <= gnt[0] ? GNT_I : GNT_D;
                        addr_q  <= gnt[0] ? (l1i_req_addr & LINE_MASK) : (l1d_req_addr & WORD_MASK);
                        we_q    <= gnt[1] && !gnt[0] && l1d_req_we;
                        wdata_q <= l1d_req_wdata;
                        be_q    <= l1d_req_be;
                    end
                end
                I_FILL, D_ACC: begin
                    if (accept) issue_cnt <= issue_cnt + CNT_W'(1);
                    if (ack_ok) ack_cnt   <= ack_cnt + CNT_W'(1);
                end
                default: ;
            endcase
            line_q <= line_nxt;
            if (last_ack && (state == I_FILL)) i_data_q <= line_nxt;
            if (last_ack && (state == D_ACC))  d_data_q <= we_q ? '0 : wb.wb_dat_i;
        end
    end
endmodule

// File: tb/tb_l1_mau_arb.sv
// Directed bench for l1_mau_arb with a scripted Wishbone slave (stall mask, ack delay, stray acks).
module tb_l1_mau_arb;
    import l1_mau_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          l1i_req_val, l1i_req_ack;
    logic [31:0]   l1i_req_addr;
    logic [255:0]  l1i_ack_data;
    logic          l1d_req_val, l1d_req_we, l1d_req_ack;
    logic [31:0]   l1d_req_addr, l1d_req_wdata, l1d_ack_data;
    logic [3:0]    l1d_req_be;

    l1_mau_arb_if wb ();

    l1_mau_arb dut (
        .clk(clk), .rst_n(rst_n),
        .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
        .l1i_req_ack(l1i_req_ack), .l1i_ack_data(l1i_ack_data),
        .l1d_req_val(l1d_req_val), .l1d_req_we(l1d_req_we), .l1d_req_addr(l1d_req_addr),
        .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be),
        .l1d_req_ack(l1d_req_ack), .l1d_ack_data(l1d_ack_data),
        .wb(wb.master)
    );

    int errors = 0;
    int checks = 0;

    // slave configuration (written by tests) and slave state (written by the slave only)
    logic [15:0] stall_mask = '0;
    int          ack_dly = 1;
    bit          inject_stall = 1'b0;
    int          clr_req = 0, extra_req = 0;
    int          clr_done = 0, extra_done = 0;
    int          win = 0, acc_cnt = 0, ack_cnt = 0, last_ack_win = 0;
    logic [15:0] stall_done = '0;
    logic [31:0] adr_log [16];
    logic [31:0] dat_log [16];
    logic [3:0]  sel_log [16];
    logic        we_log  [16];
    int          due_q[$];
    logic [31:0] pend_q[$];

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [255:0] build_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = rdata(base + 32'(4 * k));
        return l;
    endfunction

    initial begin
        bit stalled_now;
        wb.wb_ack_i = 1'b0; wb.wb_stall_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            win++;
            wb.wb_ack_i   = 1'b0;
            wb.wb_stall_i = 1'b0;
            wb.wb_dat_i   = 32'hBAD0_0000 | (32'(win) & 32'h0000_FFFF);
            stalled_now   = 1'b0;
            if (clr_req != clr_done) begin
                clr_done = clr_req; acc_cnt = 0; ack_cnt = 0; stall_done = '0;
                due_q.delete(); pend_q.delete();
            end
            if (!rst_n) begin
                due_q.delete(); pend_q.delete();
            end else begin
                if (wb.wb_cyc_o && wb.wb_stb_o) begin
                    if (acc_cnt < 16 && stall_mask[acc_cnt[3:0]] && !stall_done[acc_cnt[3:0]]) begin
                        stall_done[acc_cnt[3:0]] = 1'b1;
                        wb.wb_stall_i = 1'b1;
                        stalled_now = 1'b1;
                    end else begin
                        if (acc_cnt < 16) begin
                            adr_log[acc_cnt[3:0]] = wb.wb_adr_o;
                            dat_log[acc_cnt[3:0]] = wb.wb_dat_o;
                            sel_log[acc_cnt[3:0]] = wb.wb_sel_o;
                            we_log[acc_cnt[3:0]]  = wb.wb_we_o;
                        end
                        due_q.push_back(win + ack_dly);
                        pend_q.push_back(wb.wb_adr_o);
                        acc_cnt++;
                    end
                end
                if (due_q.size() > 0 && due_q[0] == win) begin
                    wb.wb_ack_i = 1'b1;
                    wb.wb_dat_i = rdata(pend_q[0]);
                    void'(due_q.pop_front());
                    void'(pend_q.pop_front());
                    ack_cnt++;
                    last_ack_win = win;
                end else if (extra_req != extra_done || (stalled_now && inject_stall)) begin
                    if (extra_req != extra_done) extra_done++;
                    wb.wb_ack_i = 1'b1;
                    wb.wb_dat_i = 32'hFFFF_FFFF;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic slave_cfg(input logic [15:0] mask, input int dly, input bit inj);
        stall_mask = mask; ack_dly = dly; inject_stall = inj; clr_req++;
    endtask

    // Returns ticks until the selected ack is seen, or -1 when the budget expires.
    task automatic wait_ack(input bit is_d, output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (is_d ? l1d_req_ack : l1i_req_ack) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        l1i_req_val = 0; l1i_req_addr = '0;
        l1d_req_val = 0; l1d_req_we = 0; l1d_req_addr = '0; l1d_req_wdata = '0; l1d_req_be = '0;
        #3;
        checks++;
        if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, l1i_req_ack, l1d_req_ack} !== 5'b0 ||
            wb.wb_adr_o !== '0 || wb.wb_dat_o !== '0 || wb.wb_sel_o !== '0) begin
            errors++; $display("FAIL reset_bus: cyc=%b stb=%b adr=%h sel=%h want all 0",
                               wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o, wb.wb_sel_o);
        end
        checks++;
        if (l1i_ack_data !== '0 || l1d_ack_data !== '0) begin
            errors++; $display("FAIL reset_data: i=%h d=%h want 0", l1i_ack_data, l1d_ack_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_refill(input logic [15:0] mask, input int dly, input int exp_lat, input string nm);
        int n;
        slave_cfg(mask, dly, 1'b0);
        tick();
        l1i_req_val = 1'b1; l1i_req_addr = 32'h0000_1004;
        wait_ack(1'b0, n);
        l1i_req_val = 1'b0;
        checks++;
        if (n !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm, n, exp_lat); end
        checks++;
        if (win - last_ack_win !== 1) begin errors++; $display("FAIL %s_ack_gap: got %0d want 1", nm, win - last_ack_win); end
        checks++;
        if (wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL %s_cyc_resp: got %b want 0", nm, wb.wb_cyc_o); end
        checks++;
        if (l1i_ack_data[31:0] !== 32'h1000_EFFF) begin
            errors++; $display("FAIL %s_word0: got %h want 1000efff", nm, l1i_ack_data[31:0]);
        end
        checks++;
        if (l1i_ack_data !== build_line(32'h1000)) begin
            errors++; $display("FAIL %s_line: got %h want %h", nm, l1i_ack_data, build_line(32'h1000));
        end
        checks++;
        if (acc_cnt !== 8) begin errors++; $display("FAIL %s_strobes: got %0d want 8", nm, acc_cnt); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (adr_log[k] !== 32'h1000 + 32'(4 * k) || sel_log[k] !== 4'hF || we_log[k] !== 1'b0) begin
                errors++; $display("FAIL %s_beat%0d: adr=%h sel=%h we=%b want adr=%h sel=f we=0",
                                   nm, k, adr_log[k], sel_log[k], we_log[k], 32'h1000 + 32'(4 * k));
            end
        end
        tick();
        checks++;
        if (l1i_req_ack !== 1'b0) begin errors++; $display("FAIL %s_ack_pulse: got %b want 0", nm, l1i_req_ack); end
    endtask

    task automatic test_dword();
        int n;
        slave_cfg(16'h0000, 0, 1'b0);
        tick();
        l1d_req_val = 1'b1; l1d_req_we = 1'b1; l1d_req_addr = 32'h0000_2003;
        l1d_req_wdata = 32'hA5A5_A5A5; l1d_req_be = 4'b0100;
        wait_ack(1'b1, n);
        l1d_req_val = 1'b0;
        checks++;
        if (n !== 2) begin errors++; $display("FAIL dwr_latency: got %0d want 2", n); end
        checks++;
        if (adr_log[0] !== 32'h2000 || we_log[0] !== 1'b1 || sel_log[0] !== 4'b0100 || dat_log[0] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL dwr_beat: adr=%h we=%b sel=%b dat=%h want 2000 1 0100 a5a5a5a5",
                               adr_log[0], we_log[0], sel_log[0], dat_log[0]);
        end
        checks++;
        if (l1d_ack_data !== 32'h0 || acc_cnt !== 1 || l1i_req_ack !== 1'b0) begin
            errors++; $display("FAIL dwr_ack: data=%h strobes=%0d iack=%b want 0 1 0", l1d_ack_data, acc_cnt, l1i_req_ack);
        end
        slave_cfg(16'h0001, 2, 1'b0);
        tick();
        l1d_req_val = 1'b1; l1d_req_we = 1'b0; l1d_req_addr = 32'h0000_2008; l1d_req_be = 4'hF;
        wait_ack(1'b1, n);
        l1d_req_val = 1'b0;
        checks++;
        if (n !== 5) begin errors++; $display("FAIL drd_latency: got %0d want 5", n); end
        checks++;
        if (l1d_ack_data !== 32'h2008_DFF7 || we_log[0] !== 1'b0 || sel_log[0] !== 4'hF) begin
            errors++; $display("FAIL drd_data: data=%h we=%b sel=%h want 2008dff7 0 f", l1d_ack_data, we_log[0], sel_log[0]);
        end
        checks++;
        if (wb.wb_adr_o !== '0 || wb.wb_sel_o !== '0 || wb.wb_dat_o !== '0) begin
            errors++; $display("FAIL drd_idle_bus: adr=%h sel=%h dat=%h want 0", wb.wb_adr_o, wb.wb_sel_o, wb.wb_dat_o);
        end
    endtask

    task automatic test_back_to_back();
        grant_t order [4];
        int     nack = 0;
        int     ack_at = -10;
        rst_n = 1'b0;
        slave_cfg(16'h0000, 1, 1'b0);
        l1i_req_val = 1'b1; l1i_req_addr = 32'h0000_4000;
        l1d_req_val = 1'b1; l1d_req_we = 1'b0; l1d_req_addr = 32'h0000_3000; l1d_req_be = 4'hF;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 200 && nack < 4; i++) begin
            tick();
            if (i == ack_at + 1) begin
                checks++;
                if (wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: cyc=%b want 0", wb.wb_cyc_o); end
            end
            if (i == ack_at + 2) begin
                checks++;
                if (wb.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL b2b_next_grant: cyc=%b want 1", wb.wb_cyc_o); end
            end
            if (l1i_req_ack) begin
                order[nack] = GNT_I; nack++; ack_at = i;
                checks++;
                if (l1i_ack_data !== build_line(32'h4000)) begin
                    errors++; $display("FAIL b2b_iline: got %h want %h", l1i_ack_data, build_line(32'h4000));
                end
            end else if (l1d_req_ack) begin
                order[nack] = GNT_D; nack++; ack_at = i;
                checks++;
                if (l1d_ack_data !== 32'h3000_CFFF) begin
                    errors++; $display("FAIL b2b_dword: got %h want 3000cfff", l1d_ack_data);
                end
            end
        end
        l1i_req_val = 1'b0; l1d_req_val = 1'b0;
        checks++;
        if (nack !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d acks want 4", nack);
        end else if (order[0] !== GNT_I || order[1] !== GNT_D || order[2] !== GNT_I || order[3] !== GNT_D) begin
            errors++; $display("FAIL b2b_order: got %0d%0d%0d%0d want 0101 (0=I,1=D)",
                               order[0], order[1], order[2], order[3]);
        end
        tick(); tick();
    endtask

    task automatic test_spurious();
        int n;
        slave_cfg(16'h0000, 1, 1'b0);
        tick();
        extra_req++;
        tick(); tick();
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || l1i_req_ack !== 1'b0 || l1d_req_ack !== 1'b0) begin
            errors++; $display("FAIL spur_idle: cyc=%b iack=%b dack=%b want 0", wb.wb_cyc_o, l1i_req_ack, l1d_req_ack);
        end
        slave_cfg(16'h0011, 0, 1'b1);
        tick();
        l1i_req_val = 1'b1; l1i_req_addr = 32'h0000_5000;
        wait_ack(1'b0, n);
        l1i_req_val = 1'b0;
        extra_req++;
        checks++;
        if (n !== 11) begin errors++; $display("FAIL spur_fill_latency: got %0d want 11", n); end
        checks++;
        if (l1i_ack_data !== build_line(32'h5000) || acc_cnt !== 8) begin
            errors++; $display("FAIL spur_fill_line: got %h strobes=%0d want %h 8", l1i_ack_data, acc_cnt, build_line(32'h5000));
        end
        tick(); tick();
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || l1i_req_ack !== 1'b0 || l1i_ack_data !== build_line(32'h5000)) begin
            errors++; $display("FAIL spur_after: cyc=%b iack=%b line=%h", wb.wb_cyc_o, l1i_req_ack, l1i_ack_data);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        bit quiet = 1'b1;
        slave_cfg(16'h0000, 1, 1'b0);
        tick();
        l1i_req_val = 1'b1; l1i_req_addr = 32'h0000_6010;
        for (int i = 0; i < 50 && ack_cnt < 3; i++) tick();
        checks++;
        if (ack_cnt !== 3) begin errors++; $display("FAIL rst_mid_progress: got %0d acks want 3", ack_cnt); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_adr_o !== '0) begin
            errors++; $display("FAIL rst_mid_drop: cyc=%b stb=%b adr=%h want 0", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o);
        end
        l1i_req_val = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (l1i_req_ack !== 1'b0 || wb.wb_cyc_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL rst_mid_quiet: ack or cyc seen after reset, want none"); end
        slave_cfg(16'h0000, 1, 1'b0);
        tick();
        l1d_req_val = 1'b1; l1d_req_we = 1'b0; l1d_req_addr = 32'h0000_2010; l1d_req_be = 4'hF;
        wait_ack(1'b1, n);
        l1d_req_val = 1'b0;
        checks++;
        if (n !== 3 || l1d_ack_data !== 32'h2010_DFEF) begin
            errors++; $display("FAIL rst_mid_recover: latency=%0d data=%h want 3 2010dfef", n, l1d_ack_data);
        end
    endtask

    initial begin
        test_reset();
        test_refill(16'h0000, 1, 10, "refill");
        test_refill(16'h0024, 3, 14, "refill_stall");
        test_dword();
        test_back_to_back();
        test_spurious();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
